// File: rtl/ramb_sp_param_if.sv
// Port bundle for the single-port block RAM: enables, address, write data and read data.
interface ramb_sp_param_if #(
    parameter int WIDTH      = 2,
    parameter int ADDR_WIDTH = 11
);
    logic                  EN;
    logic                  WE;
    logic                  REGCE;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [WIDTH-1:0]      DI;
    logic [WIDTH-1:0]      DO;

    modport master (output EN, WE, REGCE, ADDR, DI, input DO);
    modport slave  (input EN, WE, REGCE, ADDR, DI, output DO);
endinterface

// File: rtl/ramb_sp_param.sv
// Parametrised single-port synchronous block RAM with selectable write-collision
// behaviour, optional output register and programmable init/reset output values.
module ramb_sp_param #(
    parameter int               WIDTH      = 2,
    parameter int               ADDR_WIDTH = 11,
    parameter int               WRITE_MODE = 0,
    parameter int               DO_REG     = 0,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    parameter logic [WIDTH-1:0] INIT_OUT   = '0,
    parameter logic [WIDTH-1:0] SRVAL      = '0
) (
    input  logic             CLK,
    input  logic             RST,
    ramb_sp_param_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (WRITE_MODE > 2 || WIDTH < 1) begin : g_bad_param
        $fatal(1, "ramb_sp_param: illegal WRITE_MODE or WIDTH");
    end

    logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};
    logic [WIDTH-1:0] latch_p0    = INIT_OUT;

    // Memory array: writes are not blocked by RST, only the output path is reset.
    always_ff @(posedge CLK) begin
        if (bus.EN && bus.WE) begin
            mem[bus.ADDR] <= bus.DI;
        end
    end

    // Stage 0: output latch. NO_CHANGE mode simply leaves it alone on a write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            latch_p0 <= SRVAL;
        end else if (bus.EN) begin
            if (!bus.WE) begin
                latch_p0 <= mem[bus.ADDR];
            end else if (WRITE_MODE == 0) begin
                latch_p0 <= bus.DI;
            end else if (WRITE_MODE == 1) begin
                latch_p0 <= mem[bus.ADDR];
            end
        end
    end

    // Stage 1: optional output register
    if (DO_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] oreg_p1 = INIT_OUT;

        always_ff @(posedge CLK) begin
            if (RST) begin
                oreg_p1 <= SRVAL;
            end else if (bus.REGCE) begin
                oreg_p1 <= latch_p0;
            end
        end

        assign bus.DO = oreg_p1;
    end else begin : g_no_oreg
        assign bus.DO = latch_p0;
    end
endmodule
